// File: rtl/sd_spi_pin_sequencer.sv
// SD-card SPI byte engine sharing a GPIO pin group with software PIO.
// When enabled, the engine owns SCLK/MOSI/CS and releases MISO. Each write to
// TXRX shifts one byte in SPI mode 0, MSB first, at a programmable SCLK rate.
module sd_spi_pin_sequencer #(
    parameter int PIN_W       = 7,
    parameter int SCLK_BIT    = 0,
    parameter int MOSI_BIT    = 1,
    parameter int MISO_BIT    = 2,
    parameter int CS_BIT      = 3,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 62
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [PIN_W-1:0] pio_out,
    input  logic [PIN_W-1:0] pio_dir,
    input  logic [PIN_W-1:0] pin_in,
    output logic [PIN_W-1:0] pin_out,
    output logic [PIN_W-1:0] pin_oe
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_en;
    logic             r_cs_level;
    logic [DIV_W-1:0] r_div;
    logic             r_busy;
    logic             r_ovr;
    logic [7:0]       r_rx;
    logic             r_sclk;
    logic             r_mosi;
    logic [7:0]       r_shreg;
    logic [2:0]       r_bitcnt;
    logic [DIV_W-1:0] r_pc;
    logic [DIV_W-1:0] r_div_lat;

    logic             w_wr;
    logic             w_wr_txrx;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_start;
    logic             w_phase_end;
    logic             w_abort;
    logic [31:0]      w_ctrl;
    logic             w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_txrx   = w_wr && (address == 2'd0);
    assign w_wr_ctrl   = w_wr && (address == 2'd1);
    assign w_wr_status = w_wr && (address == 2'd2);
    assign w_start     = w_wr_txrx & r_en & ~r_busy;
    assign w_phase_end = (r_pc == '0);
    // Disabling the engine abandons any byte in flight on the next clock.
    assign w_abort     = (r_state != S_IDLE) && !r_en;
    // Only [7:0], the CTRL fields and the MISO pad are meaningful inputs.
    assign w_unused    = ^{writedata, pin_in};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: two phases per bit, eight bits per byte.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_LOW;
            S_LOW:  if (w_phase_end) w_state_nxt = S_HIGH;
            S_HIGH: if (w_phase_end) w_state_nxt = (r_bitcnt == 3'd7) ? S_IDLE : S_LOW;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // Software-visible control registers and the sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en       <= 1'b0;
            r_cs_level <= 1'b1;
            r_div      <= DIV_W'(DEFAULT_DIV);
            r_ovr      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= writedata[0];
                r_cs_level <= writedata[1];
                r_div      <= writedata[8 +: DIV_W];
            end
            if (w_wr_txrx && r_en && r_busy)
                r_ovr <= 1'b1;
            else if (w_wr_status && writedata[1])
                r_ovr <= 1'b0;
        end
    end

    // Shift engine: phase counter, SCLK/MOSI generation and MISO capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy    <= 1'b0;
            r_rx      <= 8'h00;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_shreg   <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_pc      <= '0;
            r_div_lat <= '0;
        end else if (w_abort) begin
            r_busy <= 1'b0;
            r_sclk <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_busy    <= 1'b1;
                        r_shreg   <= writedata[7:0];
                        r_mosi    <= writedata[7];
                        r_sclk    <= 1'b0;
                        r_bitcnt  <= 3'd0;
                        r_pc      <= r_div;
                        r_div_lat <= r_div;
                    end
                end
                S_LOW: begin
                    if (w_phase_end) begin
                        r_sclk  <= 1'b1;
                        r_shreg <= {r_shreg[6:0], pin_in[MISO_BIT]};
                        r_pc    <= r_div_lat;
                    end else begin
                        r_pc <= r_pc - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_sclk <= 1'b0;
                        r_pc   <= r_div_lat;
                        if (r_bitcnt == 3'd7) begin
                            r_rx   <= r_shreg;
                            r_busy <= 1'b0;
                        end else begin
                            r_mosi   <= r_shreg[7];
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else begin
                        r_pc <= r_pc - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // CTRL register image.
    always_comb begin
        w_ctrl             = '0;
        w_ctrl[0]          = r_en;
        w_ctrl[1]          = r_cs_level;
        w_ctrl[8 +: DIV_W] = r_div;
    end

    // Registered read mux, refreshed every clock from the selected register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'h0;
        end else begin
            case (address)
                2'd0:    readdata <= {24'h0, r_rx};
                2'd1:    readdata <= w_ctrl;
                2'd2:    readdata <= {30'h0, r_ovr, r_busy};
                default: readdata <= 32'h0;
            endcase
        end
    end

    // Pad mux: PIO by default, engine takes SCLK/MOSI/CS and releases MISO.
    always_comb begin
        pin_out = pio_out;
        pin_oe  = pio_dir;
        if (r_en) begin
            pin_out[SCLK_BIT] = r_sclk;
            pin_out[MOSI_BIT] = r_mosi;
            pin_out[CS_BIT]   = r_cs_level;
            pin_oe[SCLK_BIT]  = 1'b1;
            pin_oe[MOSI_BIT]  = 1'b1;
            pin_oe[CS_BIT]    = 1'b1;
            pin_oe[MISO_BIT]  = 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_spi_pin_sequencer.sv
// Bench for sd_spi_pin_sequencer: register access, pin mux, byte transfers,
// overrun, mid-transfer disable and asynchronous reset.
module tb_sd_spi_pin_sequencer;

    localparam int SCLK_BIT = 0;
    localparam int MOSI_BIT = 1;
    localparam int MISO_BIT = 2;
    localparam int CS_BIT   = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [6:0]  pio_out = 7'h0;
    logic [6:0]  pio_dir = 7'h0;
    logic [6:0]  pin_in;
    logic [6:0]  pin_out;
    logic [6:0]  pin_oe;

    logic [6:0]  pin_in_base = 7'h0;
    logic        loopback = 1'b0;
    logic        miso_force = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic       q_mosi[$];
    logic [7:0] q_rx[$];

    sd_spi_pin_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pio_out    (pio_out),
        .pio_dir    (pio_dir),
        .pin_in     (pin_in),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe)
    );

    always #5 clk = ~clk;

    // MISO pad either loops back MOSI or is held at a fixed level.
    always_comb begin
        pin_in           = pin_in_base;
        pin_in[MISO_BIT] = loopback ? pin_out[MOSI_BIT] : miso_force;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic push_byte(input logic [7:0] tx, input logic [7:0] exp_rx);
        for (int i = 7; i >= 0; i--) q_mosi.push_back(tx[i]);
        q_rx.push_back(exp_rx);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] d;
        rd(2'd0, d);
        if (q_rx.size() == 0) chk({tag, " rx queue"}, 32'd0, 32'd1);
        else                  chk({tag, " rx"}, d, {24'h0, q_rx.pop_front()});
    endtask

    // Runs one full byte, watching busy through STATUS and SCLK/MOSI on the pads.
    task automatic xfer(input logic [7:0] tx, input int div, input logic [7:0] exp_rx, input string tag);
        int   busy_cyc = 0;
        int   rises = 0;
        bit   seen = 0;
        bit   mosi_ok = 1;
        bit   oe_ok = 1;
        bit   cs_ok = 1;
        logic ps, pm;
        push_byte(tx, exp_rx);
        wr(2'd0, {24'h0, tx});
        address = 2'd2;
        ps = pin_out[SCLK_BIT];
        pm = pin_out[MOSI_BIT];
        for (int k = 0; k < 16 * (div + 1) + 20; k++) begin
            tick();
            if (readdata[0]) begin busy_cyc++; seen = 1; end
            if (pin_oe[MISO_BIT] !== 1'b0) oe_ok = 0;
            if (pin_oe[CS_BIT] !== 1'b1 || pin_out[CS_BIT] !== 1'b0) cs_ok = 0;
            if (pin_out[MOSI_BIT] !== pm && pin_out[SCLK_BIT] !== 1'b0) mosi_ok = 0;
            if (!ps && pin_out[SCLK_BIT]) begin
                rises++;
                if (q_mosi.size() == 0) chk({tag, " mosi queue"}, 32'd0, 32'd1);
                else chk($sformatf("%s mosi bit%0d", tag, rises), {31'h0, pin_out[MOSI_BIT]},
                         {31'h0, q_mosi.pop_front()});
            end
            ps = pin_out[SCLK_BIT];
            pm = pin_out[MOSI_BIT];
            if (seen && !readdata[0]) break;
        end
        chk({tag, " busy clks"}, busy_cyc, 16 * (div + 1));
        chk({tag, " sclk rises"}, rises, 8);
        chk({tag, " mosi stable while sclk high"}, {31'h0, mosi_ok}, 32'd1);
        chk({tag, " miso oe low"}, {31'h0, oe_ok}, 32'd1);
        chk({tag, " cs driven"}, {31'h0, cs_ok}, 32'd1);
        check_rx(tag);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        address = 2'd2;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!readdata[0]) begin done = 1; break; end
        end
        chk({tag, " idle reached"}, {31'h0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int r;

        // Test 1: reset values and transparent PIO mux.
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        rd(2'd0, d); chk("reset TXRX", d, 32'h0);
        rd(2'd1, d); chk("reset CTRL", d, 32'h0000_3E02);
        rd(2'd2, d); chk("reset STATUS", d, 32'h0);
        rd(2'd3, d); chk("reserved reads 0", d, 32'h0);
        for (int i = 0; i < 4; i++) begin
            pio_out     = 7'($urandom);
            pio_dir     = 7'($urandom);
            pin_in_base = 7'($urandom);
            #1;
            chk($sformatf("pio out %0d", i), {25'h0, pin_out}, {25'h0, pio_out});
            chk($sformatf("pio oe %0d", i), {25'h0, pin_oe}, {25'h0, pio_dir});
        end

        // Test 2: fastest rate, loopback.
        loopback = 1'b1;
        wr(2'd1, 32'h0000_0001);
        xfer(8'hA5, 0, 8'hA5, "t2 A5");

        // Test 3: div=3, MISO held high, all-zero byte out.
        loopback   = 1'b0;
        miso_force = 1'b1;
        wr(2'd1, 32'h0000_0301);
        xfer(8'h00, 3, 8'hFF, "t3 00");

        // Test 4: overrun while busy, then clear.
        loopback = 1'b1;
        wr(2'd1, 32'h0000_0001);
        q_rx.push_back(8'h3C);
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'h55);
        rd(2'd2, d); chk("t4 STATUS busy+ovr", d, 32'h3);
        wait_idle("t4");
        rd(2'd2, d); chk("t4 ovr sticky", d, 32'h2);
        check_rx("t4");
        wr(2'd2, 32'h2);
        rd(2'd2, d); chk("t4 ovr cleared", d, 32'h0);

        // Test 5: disable after the third SCLK rise.
        wr(2'd1, 32'h0000_0301);
        wr(2'd0, 32'h81);
        address = 2'd2;
        r = 0;
        for (int k = 0; k < 200 && r < 3; k++) begin
            logic ps;
            ps = pin_out[SCLK_BIT];
            tick();
            if (!ps && pin_out[SCLK_BIT]) r++;
        end
        chk("t5 third rise reached", r, 3);
        wr(2'd1, 32'h0000_0300);
        chk("t5 pins follow pio out", {25'h0, pin_out}, {25'h0, pio_out});
        chk("t5 pins follow pio oe", {25'h0, pin_oe}, {25'h0, pio_dir});
        address = 2'd2;
        tick();
        tick();
        chk("t5 busy dropped", readdata, 32'h0);
        wr(2'd1, 32'h0000_0301);
        chk("t5 sclk low", {31'h0, pin_out[SCLK_BIT]}, 32'h0);
        rd(2'd2, d); chk("t5 stays idle", d, 32'h0);
        rd(2'd0, d); chk("t5 rx kept", d, 32'h3C);

        // Test 6: asynchronous reset mid-transfer, then a clean byte.
        wr(2'd1, 32'h0000_0201);
        wr(2'd0, 32'hC3);
        repeat (5) tick();
        reset_n = 1'b0;
        #2;
        chk("t6 readdata async", readdata, 32'h0);
        chk("t6 pin_out async", {25'h0, pin_out}, {25'h0, pio_out});
        chk("t6 pin_oe async", {25'h0, pin_oe}, {25'h0, pio_dir});
        tick();
        reset_n = 1'b1;
        tick();
        rd(2'd1, d); chk("t6 CTRL after reset", d, 32'h0000_3E02);
        rd(2'd2, d); chk("t6 STATUS after reset", d, 32'h0);
        rd(2'd0, d); chk("t6 TXRX after reset", d, 32'h0);
        wr(2'd1, 32'h0000_0101);
        xfer(8'h5A, 1, 8'h5A, "t6 5A");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
